// File: rtl/forward_pass_mac.sv
// Forward pass of the 2-layer net: hidden MACs, output MAC, done pulse.
// Optional FWD_SAT_EN: saturate instead of wrap when narrowing results.
module forward_pass_mac #(
    parameter int NUM_IN    = 2,
    parameter int NUM_HID   = 2,
    parameter int HID_SHIFT = 2,
    parameter int AW        = 4,
    localparam int SW = (NUM_HID > 1) ? $clog2(NUM_HID) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [4*NUM_IN-1:0] x_i,
    output logic [AW-1:0]       w_addr_o,
    output logic                w_rd_o,
    input  logic [7:0]          w_data_i,
    input  logic [SW-1:0]       hid_sel_i,
    output logic [9:0]          hidden_val_o,
    output logic [18:0]         final_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HID_MAC = 3'd1;
    localparam logic [2:0] S_HID_WB  = 3'd2;
    localparam logic [2:0] S_OUT_MAC = 3'd3;
    localparam logic [2:0] S_OUT_WB  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int CMAX = (NUM_IN > NUM_HID) ? NUM_IN : NUM_HID;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int JW   = (NUM_HID > 1) ? $clog2(NUM_HID) : 1;

    logic [2:0]    state_q;
    logic [CW-1:0] i_q;
    logic [JW-1:0] j_q;
    logic [3:0]    x_q [NUM_IN];
    logic [9:0]    hid_q [NUM_HID];
    logic [19:0]   acc_q;
    logic [18:0]   final_q;

    logic [9:0]    opa;
    logic [17:0]   prod;
    logic [19:0]   acc_nxt;
    logic [19:0]   shifted;
    logic [9:0]    hid_new;
    logic [18:0]   final_new;

    // Pick the operand paired with the weight returned this cycle
    always_comb begin
        opa = '0;
        unique case (state_q)
            S_HID_MAC: begin
                for (int k = 0; k < NUM_IN; k++) begin
                    if (k + 1 == int'(i_q)) opa = 10'(x_q[k]);
                end
            end
            S_HID_WB: opa = 10'(x_q[NUM_IN-1]);
            S_OUT_MAC: begin
                for (int k = 0; k < NUM_HID; k++) begin
                    if (k + 1 == int'(i_q)) opa = hid_q[k];
                end
            end
            S_OUT_WB: opa = hid_q[NUM_HID-1];
            default: opa = '0;
        endcase
    end

    // Multiply-accumulate and narrowing of the written-back values
    always_comb begin
        prod    = 18'(opa) * 18'(w_data_i);
        acc_nxt = acc_q + 20'(prod);
        shifted = acc_nxt >> HID_SHIFT;
`ifdef FWD_SAT_EN
        hid_new   = (shifted > 20'd1023) ? 10'h3FF : 10'(shifted);
        final_new = (acc_nxt > 20'd524287) ? 19'h7FFFF : 19'(acc_nxt);
`else
        hid_new   = 10'(shifted);
        final_new = 19'(acc_nxt);
`endif
    end

    // Weight read port: one read per MAC cycle, idle otherwise
    always_comb begin
        w_rd_o   = 1'b0;
        w_addr_o = '0;
        unique case (state_q)
            S_HID_MAC: begin
                w_rd_o   = 1'b1;
                w_addr_o = AW'(int'(j_q) * NUM_IN + int'(i_q));
            end
            S_OUT_MAC: begin
                w_rd_o   = 1'b1;
                w_addr_o = AW'(NUM_HID * NUM_IN + int'(i_q));
            end
            default: begin
                w_rd_o   = 1'b0;
                w_addr_o = '0;
            end
        endcase
    end

    // Status flags and the selectable hidden readout
    always_comb begin
        done_o       = (state_q == S_DONE);
        busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
        final_o      = final_q;
        hidden_val_o = '0;
        for (int k = 0; k < NUM_HID; k++) begin
            if (k == int'(hid_sel_i)) hidden_val_o = hid_q[k];
        end
    end

    // Sequencer and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            final_q <= '0;
            for (int k = 0; k < NUM_IN; k++) x_q[k] <= '0;
            for (int k = 0; k < NUM_HID; k++) hid_q[k] <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        for (int k = 0; k < NUM_IN; k++) begin
                            x_q[k] <= x_i[4*k +: 4];
                        end
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        state_q <= S_HID_MAC;
                    end
                end
                S_HID_MAC: begin
                    acc_q <= acc_nxt;
                    if (int'(i_q) == NUM_IN - 1) begin
                        i_q     <= '0;
                        state_q <= S_HID_WB;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                S_HID_WB: begin
                    for (int k = 0; k < NUM_HID; k++) begin
                        if (k == int'(j_q)) hid_q[k] <= hid_new;
                    end
                    acc_q <= '0;
                    i_q   <= '0;
                    if (int'(j_q) == NUM_HID - 1) begin
                        state_q <= S_OUT_MAC;
                    end else begin
                        j_q     <= j_q + 1'b1;
                        state_q <= S_HID_MAC;
                    end
                end
                S_OUT_MAC: begin
                    acc_q <= acc_nxt;
                    if (int'(i_q) == NUM_HID - 1) begin
                        i_q     <= '0;
                        state_q <= S_OUT_WB;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                S_OUT_WB: begin
                    final_q <= final_new;
                    acc_q   <= '0;
                    state_q <= S_DONE;
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
